phy_rx: RTL and testbench

PHY_RX -- requirements
Module: phy_rx

---
 rtl/phy_rx_if.sv | 31 +++
 rtl/phy_rx.sv | 218 +++++++++++++++++++++
 tb/tb_phy_rx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/phy_rx_if.sv
// phy_rx_if -- GMII receive side plus frame-byte output stream of phy_rx.
//   in_rxdv / in_rxer / in_rxd : GMII receive data valid, error, data byte
//   out_valid / out_data       : frame byte strobe and byte (DA through FCS)
//   out_sof / out_eof          : first / last frame byte, qualified by out_valid
//   out_err                    : frame bad, meaningful only with out_eof
//   out_frames_ok / _bad       : wrapping good / bad frame counters
// master modport drives GMII and observes the stream; slave modport is phy_rx.
interface phy_rx_if;
  logic        in_rxdv;
  logic        in_rxer;
  logic [7:0]  in_rxd;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] out_frames_ok;
  logic [15:0] out_frames_bad;

  modport master (
    output in_rxdv, in_rxer, in_rxd,
    input  out_valid, out_data, out_sof, out_eof, out_err,
    input  out_frames_ok, out_frames_bad
  );

  modport slave (
    input  in_rxdv, in_rxer, in_rxd,
    output out_valid, out_data, out_sof, out_eof, out_err,
    output out_frames_ok, out_frames_bad
  );
endinterface

// File: rtl/phy_rx.sv
// phy_rx -- GMII receive framer.
// Strips preamble/SFD, emits frame bytes (DA..FCS) with sof/eof/err markers at
// a fixed latency (byte sampled at edge n is presented after edge n+2), flags
// frames bad on rxer, short length or over-length, and counts good/bad frames.
// Ports:
//   in_clock   : receive clock, rising edge
//   in_reset_n : asynchronous active-low reset
//   rx         : phy_rx_if.slave (GMII inputs, byte stream and counters out)
// Parameters: MIN_FRAME / MAX_FRAME, good frame length bounds incl. FCS.
// Optional: define PHY_RX_FCS_CHECK_EN to add a CRC-32 check of the FCS.
module phy_rx #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic     in_clock,
  input  logic     in_reset_n,
  phy_rx_if.slave  rx
);

  localparam int unsigned LEN_W = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] SAT_L = LEN_W'(MAX_FRAME + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;

  // stage 1: byte just accepted, waiting for the next rxdv to decide eof
  logic             s1_valid_q, s1_valid_d;
  logic [7:0]       s1_data_q, s1_data_d;
  logic             s1_sof_q, s1_sof_d;

  // stage 2: byte with its final sof/eof/err markers
  logic             s2_valid_q, s2_valid_d;
  logic [7:0]       s2_data_q, s2_data_d;
  logic             s2_sof_q, s2_sof_d;
  logic             s2_eof_q, s2_eof_d;
  logic             s2_err_q, s2_err_d;

  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_err_q, out_err_d;
  logic [15:0]      ok_cnt_q, ok_cnt_d;
  logic [15:0]      bad_cnt_q, bad_cnt_d;

  logic             frame_bad;

`ifdef PHY_RX_FCS_CHECK_EN
  logic [31:0]      crc_q, crc_d;
  logic             crc_bad;

  // Reflected CRC-32, one byte LSB first, no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The reflected register holds the bit-reversed form of the MSB-first residue.
  assign crc_bad = (bit_rev32(crc_q) != 32'hC704DD7B);
  assign frame_bad = err_q | (len_q < MIN_L) | crc_bad;
`else
  assign frame_bad = err_q | (len_q < MIN_L);
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    err_d      = err_q;
`ifdef PHY_RX_FCS_CHECK_EN
    crc_d      = crc_q;
`endif
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_sof_d   = s1_sof_q;
    s2_valid_d = s1_valid_q;
    s2_data_d  = s1_data_q;
    s2_sof_d   = s1_sof_q;
    s2_eof_d   = 1'b0;
    s2_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (rx.in_rxdv) state_d = (rx.in_rxd == 8'h55) ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!rx.in_rxdv)             state_d = S_IDLE;
        else if (rx.in_rxd == 8'hD5) begin
          state_d = S_DATA;
          len_d   = '0;
          err_d   = 1'b0;
`ifdef PHY_RX_FCS_CHECK_EN
          crc_d   = '1;
`endif
        end
        else if (rx.in_rxd != 8'h55) state_d = S_DROP;
      end
      S_DATA: begin
        if (!rx.in_rxdv) begin
          // stage-1 byte (if any) is the last one; an empty frame emits nothing
          state_d  = S_IDLE;
          s2_eof_d = 1'b1;
          s2_err_d = frame_bad;
        end else if (len_q >= MAX_L) begin
          // byte MAX_FRAME+1 is swallowed and the pending byte closes the frame
          state_d  = S_DROP;
          len_d    = SAT_L;
          s2_eof_d = 1'b1;
          s2_err_d = 1'b1;
        end else begin
          s1_valid_d = 1'b1;
          s1_data_d  = rx.in_rxd;
          s1_sof_d   = (len_q == '0);
          len_d      = len_q + 1'b1;
          err_d      = err_q | rx.in_rxer;
`ifdef PHY_RX_FCS_CHECK_EN
          crc_d      = crc32_byte(crc_q, rx.in_rxd);
`endif
        end
      end
      S_DROP: begin
        if (!rx.in_rxdv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = s2_valid_q;
    out_data_d  = s2_valid_q ? s2_data_q : '0;
    out_sof_d   = s2_valid_q & s2_sof_q;
    out_eof_d   = s2_valid_q & s2_eof_q;
    out_err_d   = s2_valid_q & s2_eof_q & s2_err_q;
    ok_cnt_d    = ok_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (s2_valid_q && s2_eof_q) begin
      if (s2_err_q) bad_cnt_d = bad_cnt_q + 16'd1;
      else          ok_cnt_d  = ok_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      err_q       <= 1'b0;
`ifdef PHY_RX_FCS_CHECK_EN
      crc_q       <= '1;
`endif
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_sof_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_sof_q    <= 1'b0;
      s2_eof_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      ok_cnt_q    <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      err_q       <= err_d;
`ifdef PHY_RX_FCS_CHECK_EN
      crc_q       <= crc_d;
`endif
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_sof_q    <= s1_sof_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_sof_q    <= s2_sof_d;
      s2_eof_q    <= s2_eof_d;
      s2_err_q    <= s2_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      ok_cnt_q    <= ok_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign rx.out_valid      = out_valid_q;
  assign rx.out_data       = out_data_q;
  assign rx.out_sof        = out_sof_q;
  assign rx.out_eof        = out_eof_q;
  assign rx.out_err        = out_err_q;
  assign rx.out_frames_ok  = ok_cnt_q;
  assign rx.out_frames_bad = bad_cnt_q;

endmodule

// File: tb/tb_phy_rx.sv
// tb_phy_rx -- self-checking bench for phy_rx: table of frame vectors plus
// hand-written preamble, empty-frame and mid-frame reset sequences.
module tb_phy_rx;
  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  phy_rx_if bus();

  phy_rx #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
    .in_clock   (clk),
    .in_reset_n (rst_n),
    .rx         (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
  } beat_t;

  typedef struct {
    int len;
    int corrupt;   // 1-based byte to XOR with 0x01, 0 = none
    int rxer;      // 1-based byte carrying rxer, 0 = none
    bit err;
  } vec_t;

  beat_t       exp_q[$];
  logic [7:0]  frm[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          out_idx = 0;
  logic [15:0] exp_ok = '0;
  logic [15:0] exp_bad = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard: every presented byte is compared with the oldest expectation.
  always @(negedge clk) begin
    beat_t act, e;
    if (rst_n && bus.out_valid) begin
      act = {bus.out_data, bus.out_sof, bus.out_eof, bus.out_err};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_byte: got data 0x%0h sof %0b eof %0b err %0b, expected no output",
                 act.data, act.sof, act.eof, act.err);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_bad++;
          $display("FAIL byte[%0d]: got data 0x%0h sof %0b eof %0b err %0b, expected data 0x%0h sof %0b eof %0b err %0b",
                   out_idx, act.data, act.sof, act.eof, act.err, e.data, e.sof, e.eof, e.err);
        end
      end
      out_idx++;
    end
  end

  function automatic logic [31:0] fcs_of_frame(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int len, input bit no_55);
    logic [7:0]  b;
    logic [31:0] fcs;
    frm.delete();
    for (int i = 0; i < ((len >= 4) ? len - 4 : len); i++) begin
      b = 8'($urandom_range(0, 255));
      if (no_55 && b == 8'h55) b = 8'h56;
      frm.push_back(b);
    end
    if (len >= 4) begin
      fcs = fcs_of_frame(len - 4);
      for (int i = 0; i < 4; i++) begin
        b = fcs[8*i +: 8];
        if (no_55 && b == 8'h55) b = 8'h56;
        frm.push_back(b);
      end
    end
  endtask

  task automatic push_expect(input int n, input bit err);
    for (int i = 0; i < n; i++)
      exp_q.push_back({frm[i], (i == 0), (i == n - 1), (i == n - 1) && err});
  endtask

  task automatic drive_byte(input logic [7:0] d, input logic er);
    @(negedge clk);
    bus.in_rxdv = 1'b1;
    bus.in_rxd  = d;
    bus.in_rxer = er;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_rxdv = 1'b0;
      bus.in_rxer = 1'b0;
      bus.in_rxd  = 8'h00;
    end
  endtask

  task automatic drive_frame(input int rxer_idx);
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) drive_byte(frm[i], (i + 1 == rxer_idx));
    drive_idle(1);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    drive_idle(6);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_counters(input string name);
    check({name, "_frames_ok"},  32'(bus.out_frames_ok),  32'(exp_ok));
    check({name, "_frames_bad"}, 32'(bus.out_frames_bad), 32'(exp_bad));
  endtask

  task automatic good_frame(input string name);
    build_frame(64, 1'b0);
    push_expect(64, 1'b0);
    drive_frame(0);
    drain(name);
    exp_ok++;
    check_counters(name);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    logic [7:0] junk[23];
    int n_out;

    tbl[0] = '{64,   0,  0, 1'b0};
`ifdef PHY_RX_FCS_CHECK_EN
    tbl[1] = '{64,   20, 0, 1'b1};
`else
    tbl[1] = '{64,   20, 0, 1'b0};
`endif
    tbl[2] = '{64,   0,  10, 1'b1};
    tbl[3] = '{1600, 0,  0, 1'b1};
    tbl[4] = '{1,    0,  0, 1'b1};
    tbl[5] = '{63,   0,  0, 1'b1};
    tbl[6] = '{65,   0,  0, 1'b0};
    tbl[7] = '{1518, 0,  0, 1'b0};
    tbl[8] = '{1519, 0,  0, 1'b1};

    bus.in_rxdv = 1'b0;
    bus.in_rxer = 1'b0;
    bus.in_rxd  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_sof",   32'(bus.out_sof),   32'd0);
    check("rst_out_eof",   32'(bus.out_eof),   32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check_counters("rst");
    rst_n = 1'b1;
    drive_idle(2);

    foreach (tbl[k]) begin
      build_frame(tbl[k].len, 1'b0);
      if (tbl[k].corrupt != 0) frm[tbl[k].corrupt - 1] = frm[tbl[k].corrupt - 1] ^ 8'h01;
      n_out = (tbl[k].len > MAX_FRAME) ? MAX_FRAME : tbl[k].len;
      push_expect(n_out, tbl[k].err);
      drive_frame(tbl[k].rxer);
      drain($sformatf("vec%0d_len%0d", k, tbl[k].len));
      if (tbl[k].err) exp_bad++;
      else            exp_ok++;
      check_counters($sformatf("vec%0d", k));
    end

    // Broken preamble: the burst, including an embedded 0x55..0xD5, is dropped.
    junk = '{8'h55, 8'h55, 8'h12, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
             8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
             8'h0A, 8'h0B, 8'h0C};
    foreach (junk[i]) drive_byte(junk[i], 1'b0);
    drive_idle(1);
    drain("bad_preamble");
    check_counters("bad_preamble");
    good_frame("after_bad_preamble");

    // SFD immediately followed by rxdv low: nothing emitted, nothing counted.
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    drive_idle(1);
    drain("empty_frame");
    check_counters("empty_frame");

    // Reset at frame byte 30: bytes 1..27 have been presented, nothing after.
    build_frame(64, 1'b1);
    push_expect(27, 1'b0);
    exp_q[26].eof = 1'b0;
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b0);
    drive_byte(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) drive_byte(frm[i], 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_eof",   32'(bus.out_eof),   32'd0);
    check("midrst_pending",   32'(exp_q.size()),  32'd0);
    exp_q.delete();
    exp_ok  = '0;
    exp_bad = '0;
    check_counters("midrst");
    for (int i = 30; i < 64; i++) begin
      drive_byte(frm[i], 1'b0);
      if (i == 32) rst_n = 1'b1;
    end
    drive_idle(1);
    drain("after_reset_tail");
    check_counters("after_reset_tail");
    good_frame("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
